// File: rtl/prompt_issuer.sv
// prompt_issuer: challenge side of the prompt/answer game.
// Draws a pseudo-random direction prompt (optionally negated), derives the
// one-hot key code the player must enter, arms the answer judge, times the
// answer window and keeps score, lives and game-over state.
// Optional build macro PROMPT_ISSUER_SPEEDUP_EN shrinks the answer window by
// TIMEOUT_STEP after every correct answer, never below TIMEOUT_MIN.
// The prompt is drawn from the LFSR on the edge that launches a round, so the
// LFSR value present when start is seen selects the first prompt; GEN then
// turns that prompt into the required key code.

module prompt_issuer #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000,
  parameter logic [1:0]  LIVES_INIT     = 2'd3,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter logic [15:0] TIMEOUT_STEP   = 16'd50,
  parameter logic [15:0] TIMEOUT_MIN    = 16'd200
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        answer_valid_i,
  input  logic        judge_answer_i,
  output logic        prepare_judge_o,
  output logic [1:0]  prompt_dir_o,
  output logic        prompt_not_o,
  output logic [15:0] expected_input_o,
  output logic [15:0] timer_o,
  output logic [7:0]  score_o,
  output logic [1:0]  lives_o,
  output logic        round_busy_o,
  output logic        game_over_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GEN      = 3'd1,
    ISSUE    = 3'd2,
    WAIT_ANS = 3'd3,
    RESULT   = 3'd4,
    OVER     = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [1:0]  dir_q, dir_d;
  logic        not_q, not_d;
  logic [15:0] exp_q, exp_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  score_q, score_d;
  logic [1:0]  lives_q, lives_d;
  logic        verdict_q, verdict_d;
  logic        start_prev_q;
  logic        launch;
  logic [1:0]  eff_dir;
  logic [15:0] window;

`ifdef PROMPT_ISSUER_SPEEDUP_EN
  localparam logic [16:0] STEP_FLOOR = {1'b0, TIMEOUT_MIN} + {1'b0, TIMEOUT_STEP};
  logic [15:0] window_q, window_d;
  assign window = window_q;
`else
  logic unused_speedup;
  assign window         = TIMEOUT_CYCLES;
  assign unused_speedup = ^{TIMEOUT_STEP, TIMEOUT_MIN};
`endif

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward the MSB
  assign lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign eff_dir = not_q ? (dir_q ^ 2'b01) : dir_q;

  // Next-state logic for the round sequencer and its score/lives/timer datapath
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    not_d     = not_q;
    exp_d     = exp_q;
    timer_d   = timer_q;
    score_d   = score_q;
    lives_d   = lives_q;
    verdict_d = verdict_q;
    launch    = 1'b0;
`ifdef PROMPT_ISSUER_SPEEDUP_EN
    window_d  = window_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_i) launch = 1'b1;
      end
      GEN: begin
        exp_d   = 16'h0001 << eff_dir;
        state_d = ISSUE;
      end
      ISSUE: begin
        timer_d = window - 16'd1;
        state_d = WAIT_ANS;
      end
      WAIT_ANS: begin
        if (answer_valid_i) begin
          verdict_d = judge_answer_i;
          timer_d   = 16'd0;
          state_d   = RESULT;
        end else if (timer_q == 16'd0) begin
          verdict_d = 1'b0;
          state_d   = RESULT;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      RESULT: begin
        timer_d = 16'd0;
        if (verdict_q) begin
          if (score_q != 8'hFF) score_d = score_q + 8'd1;
`ifdef PROMPT_ISSUER_SPEEDUP_EN
          if ({1'b0, window_q} >= STEP_FLOOR) window_d = window_q - TIMEOUT_STEP;
          else                                window_d = TIMEOUT_MIN;
`endif
        end else begin
          lives_d = lives_q - 2'd1;
        end
        if (!verdict_q && (lives_q == 2'd1)) state_d = OVER;
        else                                 launch  = 1'b1;
      end
      OVER: begin
        if (start_i && !start_prev_q) begin
          score_d = 8'd0;
          lives_d = LIVES_INIT;
          launch  = 1'b1;
`ifdef PROMPT_ISSUER_SPEEDUP_EN
          window_d = TIMEOUT_CYCLES;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    if (launch) begin
      state_d = GEN;
      dir_d   = lfsr_q[1:0];
      not_d   = lfsr_q[2];
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      lfsr_q       <= LFSR_SEED;
      dir_q        <= 2'd0;
      not_q        <= 1'b0;
      exp_q        <= 16'd0;
      timer_q      <= 16'd0;
      score_q      <= 8'd0;
      lives_q      <= LIVES_INIT;
      verdict_q    <= 1'b0;
      start_prev_q <= 1'b0;
`ifdef PROMPT_ISSUER_SPEEDUP_EN
      window_q     <= TIMEOUT_CYCLES;
`endif
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      dir_q        <= dir_d;
      not_q        <= not_d;
      exp_q        <= exp_d;
      timer_q      <= timer_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      verdict_q    <= verdict_d;
      start_prev_q <= start_i;
`ifdef PROMPT_ISSUER_SPEEDUP_EN
      window_q     <= window_d;
`endif
    end
  end

  assign prepare_judge_o  = (state_q == ISSUE);
  assign round_busy_o     = (state_q == GEN) || (state_q == ISSUE) || (state_q == WAIT_ANS);
  assign game_over_o      = (state_q == OVER);
  assign prompt_dir_o     = dir_q;
  assign prompt_not_o     = not_q;
  assign expected_input_o = exp_q;
  assign timer_o          = timer_q;
  assign score_o          = score_q;
  assign lives_o          = lives_q;

endmodule

// File: tb/tb_prompt_issuer.sv
// tb_prompt_issuer: directed self-checking bench for prompt_issuer.
// Walks a game through reset, a boundary-timed correct answer, three timeouts
// into game over, an edge-qualified restart, a mid-window reset, a stray
// verdict in IDLE and a seeded negated prompt. With PROMPT_ISSUER_SPEEDUP_EN
// the same flow also exercises the shrinking answer window.

module tb_prompt_issuer;

`ifdef PROMPT_ISSUER_SPEEDUP_EN
  localparam int TO   = 300;
  localparam int STEP = 50;
  localparam int MIN  = 200;
`else
  localparam int TO   = 8;
  localparam int STEP = 50;
  localparam int MIN  = 200;
`endif
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk;
  logic        reset;
  logic        start;
  logic        answerValid;
  logic        judgeAnswer;
  logic        prepareJudge;
  logic [1:0]  promptDir;
  logic        promptNot;
  logic [15:0] expectedInput;
  logic [15:0] timer;
  logic [7:0]  score;
  logic [1:0]  lives;
  logic        roundBusy;
  logic        gameOver;

  int          numChecks = 0;
  int          numFails  = 0;
  int          expScore;
  int          expLives;
  int          expWin;
  logic [15:0] mLfsr;
  logic [15:0] launchLfsr;

  prompt_issuer #(
    .TIMEOUT_CYCLES(16'(TO)),
    .LIVES_INIT(2'd3),
    .LFSR_SEED(SEED),
    .TIMEOUT_STEP(16'(STEP)),
    .TIMEOUT_MIN(16'(MIN))
  ) dut (
    .clk_i(clk),
    .reset_i(reset),
    .start_i(start),
    .answer_valid_i(answerValid),
    .judge_answer_i(judgeAnswer),
    .prepare_judge_o(prepareJudge),
    .prompt_dir_o(promptDir),
    .prompt_not_o(promptNot),
    .expected_input_o(expectedInput),
    .timer_o(timer),
    .score_o(score),
    .lives_o(lives),
    .round_busy_o(roundBusy),
    .game_over_o(gameOver)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the flow ever stalls
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Counts one comparison and reports it when observed differs from expected
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advances one clock, keeps the reference LFSR in step, then settles past the edge
  task automatic applyStimulus();
    @(posedge clk);
    if (reset) mLfsr = SEED;
    else       mLfsr = {mLfsr[14:0], mLfsr[15] ^ mLfsr[13] ^ mLfsr[12] ^ mLfsr[10]};
    #1;
  endtask

  // Prompt and key code expected from the LFSR value that launched the round
  task automatic checkPrompt(input logic [15:0] lv);
    logic [1:0] d;
    logic       n;
    logic [1:0] e;
    d = lv[1:0];
    n = lv[2];
    e = n ? {d[1], ~d[0]} : d;
    checkOutput("prompt_dir", 32'(promptDir), 32'(d));
    checkOutput("prompt_not", 32'(promptNot), 32'(n));
    checkOutput("expected_input", 32'(expectedInput), 32'd1 << e);
  endtask

  // Plays one round starting in its ISSUE cycle; answerAt<0 means let it time out.
  // Returns in the next ISSUE cycle, or in OVER when the last life is lost.
  task automatic playRound(input int answerAt, input logic verdict);
    logic [15:0] resultLfsr;
    logic        effVerdict;
    effVerdict = 1'b0;
    checkOutput("prep_pulse", 32'(prepareJudge), 32'd1);
    checkOutput("issue_timer", 32'(timer), 32'd0);
    applyStimulus();
    checkOutput("prep_single", 32'(prepareJudge), 32'd0);
    checkOutput("timer_load", 32'(timer), 32'(expWin - 1));
    for (int k = 0; k < expWin; k++) begin
      if (k == expWin - 1) begin
        checkOutput("timer_zero", 32'(timer), 32'd0);
        checkOutput("busy_wait", 32'(roundBusy), 32'd1);
      end
      if (k == answerAt) begin
        answerValid = 1'b1;
        judgeAnswer = verdict;
        effVerdict  = verdict;
        applyStimulus();
        answerValid = 1'b0;
        judgeAnswer = 1'b0;
        break;
      end
      applyStimulus();
    end
    resultLfsr = mLfsr;
    checkOutput("result_busy", 32'(roundBusy), 32'd0);
    checkOutput("result_timer", 32'(timer), 32'd0);
    checkOutput("result_lives", 32'(lives), 32'(expLives));
    if (effVerdict) begin
      if (expScore < 255) expScore++;
`ifdef PROMPT_ISSUER_SPEEDUP_EN
      if (expWin - STEP >= MIN) expWin = expWin - STEP;
      else                      expWin = MIN;
`endif
    end else begin
      expLives--;
    end
    applyStimulus();
    checkOutput("score", 32'(score), 32'(expScore));
    checkOutput("lives", 32'(lives), 32'(expLives));
    if (expLives == 0) begin
      checkOutput("over_flag", 32'(gameOver), 32'd1);
      checkOutput("over_busy", 32'(roundBusy), 32'd0);
    end else begin
      checkOutput("gen_busy", 32'(roundBusy), 32'd1);
      checkOutput("gen_prep", 32'(prepareJudge), 32'd0);
      applyStimulus();
      checkPrompt(resultLfsr);
    end
  endtask

  // Top-level directed sequence
  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    answerValid = 1'b0;
    judgeAnswer = 1'b0;
    mLfsr       = SEED;
    applyStimulus();
    applyStimulus();

    checkOutput("rst_prep", 32'(prepareJudge), 32'd0);
    checkOutput("rst_dir", 32'(promptDir), 32'd0);
    checkOutput("rst_not", 32'(promptNot), 32'd0);
    checkOutput("rst_exp", 32'(expectedInput), 32'd0);
    checkOutput("rst_timer", 32'(timer), 32'd0);
    checkOutput("rst_score", 32'(score), 32'd0);
    checkOutput("rst_lives", 32'(lives), 32'd3);
    checkOutput("rst_busy", 32'(roundBusy), 32'd0);
    checkOutput("rst_over", 32'(gameOver), 32'd0);

    // First round from the seed: lfsr[2:0]=001 -> down, not negated
    reset = 1'b0;
    start = 1'b1;
    applyStimulus();
    checkOutput("gen1_busy", 32'(roundBusy), 32'd1);
    checkOutput("gen1_prep", 32'(prepareJudge), 32'd0);
    start = 1'b0;
    applyStimulus();
    checkOutput("seed_dir", 32'(promptDir), 32'd1);
    checkOutput("seed_not", 32'(promptNot), 32'd0);
    checkOutput("seed_exp", 32'(expectedInput), 32'h0002);
    expScore = 0;
    expLives = 3;
    expWin   = TO;

    // Correct answer in the very cycle the timer reaches zero
    playRound(expWin - 1, 1'b1);

    // Three timeouts end the game; start held high across OVER entry
    playRound(-1, 1'b0);
    playRound(-1, 1'b0);
    start = 1'b1;
    playRound(-1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      answerValid = 1'b1;
      judgeAnswer = 1'b1;
      applyStimulus();
      checkOutput("held_over", 32'(gameOver), 32'd1);
      checkOutput("held_busy", 32'(roundBusy), 32'd0);
      checkOutput("held_score", 32'(score), 32'd1);
      checkOutput("held_lives", 32'(lives), 32'd0);
    end
    answerValid = 1'b0;
    judgeAnswer = 1'b0;
    start = 1'b0;
    applyStimulus();
    checkOutput("low_over", 32'(gameOver), 32'd1);
    start = 1'b1;
    launchLfsr = mLfsr;
    applyStimulus();
    checkOutput("restart_busy", 32'(roundBusy), 32'd1);
    checkOutput("restart_over", 32'(gameOver), 32'd0);
    checkOutput("restart_score", 32'(score), 32'd0);
    checkOutput("restart_lives", 32'(lives), 32'd3);
    start = 1'b0;
    applyStimulus();
    checkPrompt(launchLfsr);
    expScore = 0;
    expLives = 3;
    expWin   = TO;
    playRound(2, 1'b1);

    // Reset in the middle of the answer window
    for (int i = 0; i < expWin && timer != 16'd5; i++) applyStimulus();
    checkOutput("mid_timer", 32'(timer), 32'd5);
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    checkOutput("midrst_busy", 32'(roundBusy), 32'd0);
    checkOutput("midrst_score", 32'(score), 32'd0);
    checkOutput("midrst_lives", 32'(lives), 32'd3);
    checkOutput("midrst_timer", 32'(timer), 32'd0);
    checkOutput("midrst_prep", 32'(prepareJudge), 32'd0);
    applyStimulus();
    checkOutput("idle_prep", 32'(prepareJudge), 32'd0);

    // Stray verdict in IDLE changes nothing
    answerValid = 1'b1;
    judgeAnswer = 1'b1;
    applyStimulus();
    answerValid = 1'b0;
    judgeAnswer = 1'b0;
    applyStimulus();
    checkOutput("stray_score", 32'(score), 32'd0);
    checkOutput("stray_lives", 32'(lives), 32'd3);
    checkOutput("stray_busy", 32'(roundBusy), 32'd0);
    checkOutput("stray_prep", 32'(prepareJudge), 32'd0);

    // Launch when the LFSR shows 110: NOT left -> key code for right
    for (int g = 0; g < 64 && mLfsr[2:0] != 3'b110; g++) applyStimulus();
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    applyStimulus();
    checkOutput("neg_dir", 32'(promptDir), 32'd2);
    checkOutput("neg_not", 32'(promptNot), 32'd1);
    checkOutput("neg_exp", 32'(expectedInput), 32'h0008);
    expScore = 0;
    expLives = 3;
    expWin   = TO;
    playRound(0, 1'b1);
    playRound(1, 1'b1);
    playRound(2, 1'b1);
    playRound(0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", numChecks, numFails);
    $finish;
  end

endmodule
